// File: rtl/byte_lane_rmw_pkg.sv
// byte_lane_rmw_pkg: shared FSM states, size encodings and request legality helpers
package byte_lane_rmw_pkg;
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    function automatic logic size_legal(input logic [1:0] size, input int data_w);
        return !(size == SZ_D && data_w == 32);
    endfunction
    function automatic logic misaligned(input logic [2:0] addr_offset, input logic [1:0] size);
        return size == SZ_H ? addr_offset[0] :
               size == SZ_W ? |addr_offset[1:0] :
               size == SZ_D ? |addr_offset : 1'b0;
    endfunction
endpackage

// File: rtl/lane_mask_gen.sv
// lane_mask_gen: byte and bit lane masks for an access of 2**size bytes at a byte offset
//   size      : access size code (byte/half/word/double)
//   offset    : byte offset of the access within the DATA_W word
//   byte_mask : one bit per byte lane covered by the access
//   bit_mask  : byte_mask expanded to one bit per data bit
module lane_mask_gen
    import byte_lane_rmw_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]                  size,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    output logic [DATA_W/8-1:0]         byte_mask,
    output logic [DATA_W-1:0]           bit_mask
);
    localparam int NB = DATA_W / 8;
    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < NB; i++)
            byte_mask[i] = i >= int'(offset) && i < int'(offset) + (1 << size);
    end
    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign bit_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
endmodule

// File: rtl/byte_lane_rmw.sv
// byte_lane_rmw: sub-word load/store unit doing read-modify-write over a word-only memory port
//   req_*     : CPU request (valid/ready), address, size, sign, right-aligned store data
//   rsp_*     : CPU response (valid/ready), extended load data, error flag
//   mem_req_* : memory command (valid/ready), write enable, word address, merged write data
//   mem_r*    : memory read return (one-cycle valid pulse with data)
module byte_lane_rmw
    import byte_lane_rmw_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [1:0] FULL_SZ = 2'(OFF_W);
    state_t state, state_next;
    logic              r_write, r_signed;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [OFF_W-1:0]  req_off;
    logic              req_err, full_store;
    logic [NB-1:0]     byte_mask, lane_top, byte_msb;
    logic [DATA_W-1:0] bit_mask, merged, loaded;
    logic [OFF_W+2:0]  shamt;
    logic              sign;
    assign req_off    = req_addr[OFF_W-1:0];
    assign req_err    = !size_legal(req_size, DATA_W) || misaligned(3'(req_off), req_size);
    assign full_store = req_write && req_size == FULL_SZ;
    lane_mask_gen #(.DATA_W(DATA_W)) u_mask (
        .size     (r_size),
        .offset   (r_off),
        .byte_mask(byte_mask),
        .bit_mask (bit_mask)
    );
    // The sign bit is the msb of the highest byte lane covered by the access.
    assign lane_top = byte_mask & ~(byte_mask >> 1);
    for (genvar b = 0; b < NB; b++) begin : g_msb
        assign byte_msb[b] = mem_rdata[8*b+7];
    end
    assign shamt  = {r_off, 3'b000};
    assign sign   = r_signed && |(lane_top & byte_msb);
    assign merged = (mem_rdata & ~bit_mask) | ((r_wdata << shamt) & bit_mask);
    assign loaded = ((mem_rdata & bit_mask) >> shamt) | (sign ? ~(bit_mask >> shamt) : '0);
    assign req_ready     = state == IDLE;
    assign rsp_valid     = state == RESP;
    assign mem_req_valid = state == RD || state == WR;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_err ? RESP : full_store ? WR : RD;
            RD:      if (mem_req_ready) state_next = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_next = r_write ? WR : RESP;
            WR:      if (mem_req_ready) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= SZ_B;
            r_off     <= '0;
            r_wdata   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                r_write   <= req_write;
                r_signed  <= req_signed;
                r_size    <= req_size;
                r_off     <= req_off;
                r_wdata   <= req_wdata;
                mem_we    <= full_store && !req_err;
                mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata <= req_wdata;
                rsp_err   <= req_err;
                rsp_rdata <= '0;
            end
            if (state == RD_WAIT && mem_rvalid) begin
                if (r_write) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= merged;
                end else begin
                    rsp_rdata <= loaded;
                end
            end
        end
    end
endmodule
